// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO: register-array storage, occupancy count,
// programmable almost-full/empty thresholds, registered read port, flush and sticky errors.
module fifo_sync_param #(
  parameter int unsigned bw     = 4,
  parameter int unsigned simd   = 1,
  parameter int unsigned depth  = 64,
  parameter int unsigned af_lvl = 60,
  parameter int unsigned ae_lvl = 4,
  localparam int unsigned W     = simd * bw,
  localparam int unsigned AW    = $clog2(depth),
  localparam int unsigned PW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          wr,
  input  logic [W-1:0]  in,
  input  logic          rd,
  output logic [W-1:0]  out,
  output logic          o_valid,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_almost_full,
  output logic          o_almost_empty,
  output logic [AW:0]   o_count,
  output logic          o_overflow,
  output logic          o_underflow
);

  localparam logic [AW:0] PTR_ONE = PW'(1);
  localparam logic [AW:0] AF_LVL  = PW'(af_lvl);
  localparam logic [AW:0] AE_LVL  = PW'(ae_lvl);

  logic [W-1:0]  mem_q [depth];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic [W-1:0]  out_q,    out_d;
  logic          valid_q,  valid_d;
  logic          ovf_q,    ovf_d;
  logic          unf_q,    unf_d;

  logic          full;
  logic          empty;
  logic          wr_acc;
  logic          rd_acc;
  logic          mem_we;

  // Status derives only from registered pointers, never from same-cycle requests.
  assign full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign wr_acc = wr && !full;
  assign rd_acc = rd && !empty;
  assign mem_we = wr_acc && !clr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    out_d    = out_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        out_d    = mem_q[rd_ptr_q[AW-1:0]];
        valid_d  = 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + PTR_ONE;
        2'b01:   count_d = count_q - PTR_ONE;
        default: count_d = count_q;
      endcase
      if (wr && full) begin
        ovf_d = 1'b1;
      end
      if (rd && empty) begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is zeroed on reset so stale row data never leaks after a restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in;
    end
  end

  assign out            = out_q;
  assign o_valid        = valid_q;
  assign o_full         = full;
  assign o_empty        = empty;
  assign o_count        = count_q;
  assign o_almost_full  = (count_q >= AF_LVL);
  assign o_almost_empty = (count_q <= AE_LVL);
  assign o_overflow     = ovf_q;
  assign o_underflow    = unf_q;

endmodule
